neo_unit: RTL and testbench

NEO_UNIT -- requirements
Module: neo_unit

---
 rtl/neo_unit.sv | 129 ++++++++++++
 tb/tb_neo_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/neo_unit.sv
// neo_unit: Teager nonlinear energy operator over a 3-sample sliding window.
// psi(n) = x(n)^2 - x(n-1)*x(n+1), evaluated on the centre sample of the window.
//
// Window FSM
//   state | meaning
//   EMPTY | no samples held since reset/flush
//   ONE   | one sample held (w0)
//   TWO   | two samples held (w0, w1)
//   RUN   | full window; every accepted sample yields a result
//
// Pipeline: window shift (edge k) -> products (edge k+1) -> difference (edge k+2).
module neo_unit #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 32   // must equal 2*DIN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_valid,
  input  logic                     flush,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_en_n,
  output logic                     primed
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t state;

  logic signed [DIN_W-1:0]  w0, w1, w2;
  logic                     win_valid;

  logic signed [DOUT_W-1:0] w0_ext, w1_ext, w2_ext;
  logic signed [DOUT_W-1:0] prod_sq, prod_x;
  logic                     prod_valid;

  logic signed [DOUT_W:0]   diff;
  logic signed [DOUT_W-1:0] diff_lo;
  logic                     diff_msb_unused;

  logic                     accept;

  assign accept = din_valid && !flush;

  // Sign-extend window taps so the products are formed at full output width.
  assign w0_ext = {{(DOUT_W-DIN_W){w0[DIN_W-1]}}, w0};
  assign w1_ext = {{(DOUT_W-DIN_W){w1[DIN_W-1]}}, w1};
  assign w2_ext = {{(DOUT_W-DIN_W){w2[DIN_W-1]}}, w2};

  // Difference carries one guard bit; the reachable range fits DOUT_W, so the
  // top bit is dropped without saturation.
  assign diff = $signed({prod_sq[DOUT_W-1], prod_sq}) - $signed({prod_x[DOUT_W-1], prod_x});
  assign {diff_msb_unused, diff_lo} = diff;

  // Window shift register and fill-level FSM; flags a result once the window is full.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      state     <= EMPTY;
      primed    <= 1'b0;
      win_valid <= 1'b0;
    end else if (accept) begin
      w0        <= din;
      w1        <= w0;
      w2        <= w1;
      win_valid <= (state == TWO) || (state == RUN);
      case (state)
        EMPTY: begin
          state  <= ONE;
          primed <= 1'b0;
        end
        ONE: begin
          state  <= TWO;
          primed <= 1'b0;
        end
        TWO, RUN: begin
          state  <= RUN;
          primed <= 1'b1;
        end
        default: begin
          state  <= EMPTY;
          primed <= 1'b0;
        end
      endcase
    end else begin
      win_valid <= 1'b0;
    end
  end

  // Stage 1: square of the centre tap and cross product of the outer taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_sq    <= '0;
      prod_x     <= '0;
      prod_valid <= 1'b0;
    end else if (flush) begin
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= win_valid;
      if (win_valid) begin
        prod_sq <= w1_ext * w1_ext;
        prod_x  <= w0_ext * w2_ext;
      end
    end
  end

  // Stage 2: register the energy and strobe it for one cycle; dout holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      dout_en_n <= 1'b1;
    end else if (flush) begin
      dout_en_n <= 1'b1;
    end else begin
      dout_en_n <= !prod_valid;
      if (prod_valid) begin
        dout <= diff_lo;
      end
    end
  end

endmodule

// File: tb/tb_neo_unit.sv
// tb_neo_unit: directed vectors for neo_unit with a queue scoreboard; the
// stimulus pushes hand-computed energies, a monitor pops them on each strobe.
module tb_neo_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               flush;
  logic signed [31:0] dout;
  logic               dout_en_n;
  logic               primed;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic signed [31:0] exp_q[$];
  int                 due_q[$];

  neo_unit #(.DIN_W(16), .DOUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .flush     (flush),
    .dout      (dout),
    .dout_en_n (dout_en_n),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (dout_en_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe actual dout=%0d required no strobe (cycle %0d)", dout, cyc);
      end else begin
        logic signed [31:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("dout", dout, e);
        chk("latency_cycle", cyc, d);
      end
    end
  end

  task automatic send(input logic signed [15:0] x, input bit e_v, input logic signed [31:0] e);
    din       = x;
    din_valid = 1'b1;
    if (e_v) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 3);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_en_n", dout_en_n, 1);
    chk("reset_primed", primed, 0);
    rst = 1'b0;

    // 3, 5, 2 -> 19; then 4 -> -16 back to back
    send(16'sd3, 1'b0, 0);
    send(16'sd5, 1'b0, 0);
    chk("primed_two", primed, 0);
    send(16'sd2, 1'b1, 32'sd19);
    chk("primed_run", primed, 1);
    send(16'sd4, 1'b1, -32'sd16);
    idle(4);
    chk("hold_dout", dout, -16);
    chk("hold_en_n", dout_en_n, 1);

    // Extremes
    do_flush();
    chk("flush_primed", primed, 0);
    send(-16'sd32768, 1'b0, 0);
    send(-16'sd32768, 1'b0, 0);
    send(16'sd32767, 1'b1, 32'sd2147450880);
    idle(3);
    do_flush();
    send(-16'sd32768, 1'b0, 0);
    send(16'sd0, 1'b0, 0);
    send(-16'sd32768, 1'b1, -32'sd1073741824);
    idle(3);

    // Gaps between samples
    do_flush();
    send(16'sd1, 1'b0, 0);
    idle(2);
    send(16'sd2, 1'b0, 0);
    idle(2);
    send(16'sd3, 1'b1, 32'sd1);
    idle(4);
    chk("gap_hold_dout", dout, 1);

    // Reset right after the third sample discards the in-flight result
    do_flush();
    send(16'sd3, 1'b0, 0);
    send(16'sd5, 1'b0, 0);
    send(16'sd2, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_inflight_dout", dout, 0);
    chk("rst_inflight_en_n", dout_en_n, 1);
    chk("rst_inflight_primed", primed, 0);
    idle(4);

    // Flush with a simultaneous sample: the 9 is dropped
    send(16'sd7, 1'b0, 0);
    send(16'sd7, 1'b0, 0);
    din       = 16'sd9;
    din_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    din_valid = 1'b0;
    chk("flush_drop_primed", primed, 0);
    send(16'sd1, 1'b0, 0);
    send(16'sd1, 1'b0, 0);
    chk("flush_two_primed", primed, 0);
    send(16'sd1, 1'b1, 32'sd0);
    idle(4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
